// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store unit driving a word-wide data memory.
// Ports: req_* (in, valid/ready), resp_* (out), MemRead/MemWrite/ram_addr/write_data/read_data.
module lsu_mem_master #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] ram_addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      st;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;

  logic acc;
  logic err_c;
  logic is_sw;
  logic legal;
  logic mis;
  logic oor;

  assign req_ready = rst_n & (st == IDLE);
  assign acc = req_valid & req_ready;
  assign is_sw = req_write & (req_funct3 == 3'b010);

  always_comb begin
    legal = 1'b0;
    if (req_write)
      legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      legal = req_funct3 inside {3'b000, 3'b001, 3'b010,
                                 3'b100, 3'b101};
    mis = ((req_funct3[1:0] == 2'b01) & req_addr[0])
        | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
    oor = req_addr[31:2] >= DEPTH_W;
    err_c = ~legal | mis | oor;
  end

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [2:0]  f3
  );
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3[1:0])
      2'b00:
        ld_ext = f3[2] ? {24'h0, s[7:0]}
                       : {{24{s[7]}}, s[7:0]};
      2'b01:
        ld_ext = f3[2] ? {16'h0, s[15:0]}
                       : {{16{s[15]}}, s[15:0]};
      default: ld_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(
    input logic [31:0] old,
    input logic [15:0] wd,
    input logic [1:0]  off,
    input logic        half
  );
    logic [31:0] m;
    logic [31:0] d;
    m = half ? 32'h0000_FFFF : 32'h0000_00FF;
    d = half ? {16'h0, wd} : {24'h0, wd[7:0]};
    st_merge = (old & ~(m << {off, 3'b000}))
             | (d << {off, 3'b000});
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      r_write    <= 1'b0;
      r_f3       <= 3'b000;
      r_off      <= 2'b00;
      r_wdata    <= 16'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      ram_addr   <= 32'h0;
      write_data <= 32'h0;
    end else begin
      unique case (st)
        IDLE: begin
          if (acc) begin
            r_write  <= req_write;
            r_f3     <= req_funct3;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            ram_addr <= {2'b00, req_addr[31:2]};
            unique case (1'b1)
              err_c: begin
                st         <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_rdata <= 32'h0;
              end
              (!err_c && is_sw): begin
                st         <= WR;
                MemWrite   <= 1'b1;
                write_data <= req_wdata;
              end
              default: begin
                st      <= RD;
                MemRead <= 1'b1;
              end
            endcase
          end
        end
        RD: begin
          MemRead <= 1'b0;
          if (r_write) begin
            // sb/sh: old word was just read, write back the merge
            st         <= WR;
            MemWrite   <= 1'b1;
            write_data <= st_merge(read_data, r_wdata,
                                   r_off, r_f3[0]);
          end else begin
            st         <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_ext(read_data, r_off, r_f3);
          end
        end
        WR: begin
          MemWrite   <= 1'b0;
          st         <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
